// File: rtl/mem_data_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_data_access_pkg
// Shared types for the memory-stage data access block:
//   memControl_t  - EX/MEM request (ce, we, physical addr, byte sel, wdata,
//                   cache invalidate hints that this block ignores)
//   exOperation_t - operation code; the load kinds select alignment/extension
//   memState_t    - memory-stage FSM states
//   dbusReq_t     - registered data-bus request
// -----------------------------------------------------------------------------
package mem_data_access_pkg;

  typedef struct packed {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        invalidate_icache;
    logic        invalidate_dcache;
  } memControl_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_LL   = 4'd6,
    OP_LWL  = 4'd7,
    OP_LWR  = 4'd8,
    OP_LWC1 = 4'd9,
    OP_SB   = 4'd10,
    OP_SH   = 4'd11,
    OP_SW   = 4'd12
  } exOperation_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } memState_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } dbusReq_t;

endpackage

// File: rtl/mem_data_access_if.sv
// -----------------------------------------------------------------------------
// mem_data_access_if
// Data-bus bundle between the memory stage (master) and the bus arbiter/slave.
//   bus_req/bus_we/bus_addr/bus_sel/bus_wdata : request, driven by master
//   bus_ack   : single-cycle acknowledge, driven by slave
//   bus_rdata : read data, valid while bus_ack is high
//   bus_err   : watchdog-expiry pulse from the master
// -----------------------------------------------------------------------------
interface mem_data_access_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_data_access_load_align.sv
// -----------------------------------------------------------------------------
// mem_load_align
// Combinational load-data formatter.
//   op_i        : load kind
//   addr_lo_i   : byte offset addr[1:0] of the access
//   bus_rdata_i : raw little-endian word from the bus
//   rt_old_i    : previous rt value, merged into LWL/LWR results
//   data_o      : aligned, extended or merged load result
// -----------------------------------------------------------------------------
import mem_data_access_pkg::*;

module mem_load_align (
  input  exOperation_t op_i,
  input  logic [1:0]   addr_lo_i,
  input  logic [31:0]  bus_rdata_i,
  input  logic [31:0]  rt_old_i,
  output logic [31:0]  data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = bus_rdata_i >> {addr_lo_i, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_lo_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    data_o   = bus_rdata_i;
    case (op_i)
      OP_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: data_o = {24'h0, byte_sel};
      OP_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU: data_o = {16'h0, half_sel};
      // LWL fills the high end of rt from the addressed byte downward.
      OP_LWL: begin
        case (addr_lo_i)
          2'd0:    data_o = {bus_rdata_i[7:0],  rt_old_i[23:0]};
          2'd1:    data_o = {bus_rdata_i[15:0], rt_old_i[15:0]};
          2'd2:    data_o = {bus_rdata_i[23:0], rt_old_i[7:0]};
          default: data_o = bus_rdata_i;
        endcase
      end
      // LWR fills the low end of rt from the addressed byte upward.
      OP_LWR: begin
        case (addr_lo_i)
          2'd0:    data_o = bus_rdata_i;
          2'd1:    data_o = {rt_old_i[31:24], bus_rdata_i[31:8]};
          2'd2:    data_o = {rt_old_i[31:16], bus_rdata_i[31:16]};
          default: data_o = {rt_old_i[31:8],  bus_rdata_i[31:24]};
        endcase
      end
      default: data_o = bus_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_data_access.sv
// -----------------------------------------------------------------------------
// mem_data_access
// Memory-stage responder: issues one data-bus transaction per load/store and
// holds the pipeline until the slave acknowledges.
//   clk, rst     : clock; asynchronous active-low reset
//   req, op      : EX/MEM request and load kind
//   rt_old       : previous rt value for LWL/LWR merge
//   except_i     : instruction already faulted, suppress the access
//   flush        : pipeline flush
//   stall_i      : a later stage is holding the pipeline
//   stall_req    : hold request to the hazard unit (combinational)
//   rdata        : registered load result
//   bus          : data-bus master port (all request outputs registered)
// TIMEOUT_CYCLES > 0 enables a watchdog that abandons a silent transaction.
// -----------------------------------------------------------------------------
import mem_data_access_pkg::*;

module mem_data_access #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  memControl_t         req,
  input  exOperation_t        op,
  input  logic [31:0]         rt_old,
  input  logic                except_i,
  input  logic                flush,
  input  logic                stall_i,
  output logic                stall_req,
  output logic [31:0]         rdata,
  mem_data_access_if.master   bus
);

  memState_t   state_q, state_d;
  dbusReq_t    bus_q, bus_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] align_data;
  logic        timeout;
  logic        start;
  logic        unused_inval;

  // Cache invalidate hints travel with the request but are handled elsewhere.
  assign unused_inval = req.invalidate_icache ^ req.invalidate_dcache;

  mem_load_align u_align (
    .op_i        (op),
    .addr_lo_i   (bus_q.addr[1:0]),
    .bus_rdata_i (bus.bus_rdata),
    .rt_old_i    (rt_old),
    .data_o      (align_data)
  );

  assign start = (state_q == IDLE) && req.ce && !except_i && !flush;

  // Watchdog: counts cycles without ack while a transaction is outstanding.
  // timeout fires in the cycle the count would reach the limit, so the error
  // pulse lands TIMEOUT_CYCLES cycles after bus_req first went high.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      logic [31:0] wd_cnt_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wd_cnt_q <= '0;
        end else if (start) begin
          wd_cnt_q <= '0;
        end else if ((state_q == BUSY || state_q == ABORT) && !bus.bus_ack) begin
          wd_cnt_q <= wd_cnt_q + 32'd1;
        end
      end

      assign timeout = (wd_cnt_q == TIMEOUT_CYCLES - 1);
    end else begin : g_no_wd
      assign timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bus_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_q     <= bus_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bus_d     = bus_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bus_d.req   = 1'b1;
          bus_d.we    = req.we;
          bus_d.addr  = req.addr;
          bus_d.sel   = req.sel;
          bus_d.wdata = req.wdata;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // Ack has priority over both the watchdog and a flush.
        if (bus.bus_ack) begin
          bus_d.req = 1'b0;
          if (flush) begin
            state_d = IDLE;
          end else begin
            if (!bus_q.we) rdata_d = align_data;
            state_d = DONE;
          end
        end else if (timeout) begin
          bus_d.req = 1'b0;
          bus_err_d = 1'b1;
          rdata_d   = '0;
          state_d   = flush ? IDLE : DONE;
        end else if (flush) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        // Transaction cannot be cancelled: wait it out, discard the data.
        if (bus.bus_ack) begin
          bus_d.req = 1'b0;
          state_d   = IDLE;
        end else if (timeout) begin
          bus_d.req = 1'b0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      DONE: begin
        // Stay here while held so the same instruction is not issued again.
        if (!stall_i || flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_req     = req.ce && !except_i && (state_q != DONE);
  assign rdata         = rdata_q;
  assign bus.bus_req   = bus_q.req;
  assign bus.bus_we    = bus_q.we;
  assign bus.bus_addr  = bus_q.addr;
  assign bus.bus_sel   = bus_q.sel;
  assign bus.bus_wdata = bus_q.wdata;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_data_access.sv
// -----------------------------------------------------------------------------
// tb_mem_data_access
// Directed bench for mem_data_access with an 8-cycle watchdog. Inputs change
// 1 ns after each rising edge; outputs are observed 1 ns after that.
// -----------------------------------------------------------------------------
import mem_data_access_pkg::*;

module tb_mem_data_access;

  logic         clk = 1'b0;
  logic         rst;
  memControl_t  req;
  exOperation_t op;
  logic [31:0]  rt_old;
  logic         except_i;
  logic         flush;
  logic         stall_i;
  logic         stall_req;
  logic [31:0]  rdata;

  int compared   = 0;
  int mismatched = 0;
  int tx_cnt     = 0;
  int tx_base;
  logic req_prev = 1'b0;

  mem_data_access_if bus_if ();

  mem_data_access #(.TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .rt_old    (rt_old),
    .except_i  (except_i),
    .flush     (flush),
    .stall_i   (stall_i),
    .stall_req (stall_req),
    .rdata     (rdata),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  // Count bus transactions by rising edges of bus_req.
  always @(posedge clk) begin
    if (bus_if.bus_req && !req_prev) tx_cnt <= tx_cnt + 1;
    req_prev <= bus_if.bus_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wdata, input exOperation_t op_v, input logic [31:0] rt);
    req.ce    = 1'b1;
    req.we    = we;
    req.addr  = addr;
    req.sel   = sel;
    req.wdata = wdata;
    op        = op_v;
    rt_old    = rt;
  endtask

  // Zero-wait load: cycle 0 request, cycle 1 ack, cycle 2 DONE with result.
  task automatic do_load(input string tag, input exOperation_t op_v, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] rt,
                         input logic [31:0] mem, input logic [31:0] exp);
    cyc();
    issue(1'b0, addr, sel, 32'h0, op_v, rt);
    settle();
    chk({tag, "_stall_c0"}, {31'd0, stall_req}, 32'd1);
    chk({tag, "_req_c0"}, {31'd0, bus_if.bus_req}, 32'd0);
    cyc();
    chk({tag, "_req_c1"}, {31'd0, bus_if.bus_req}, 32'd1);
    chk({tag, "_addr_c1"}, bus_if.bus_addr, addr);
    chk({tag, "_sel_c1"}, {28'd0, bus_if.bus_sel}, {28'd0, sel});
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = mem;
    settle();
    chk({tag, "_stall_c1"}, {31'd0, stall_req}, 32'd1);
    cyc();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;
    settle();
    chk({tag, "_stall_c2"}, {31'd0, stall_req}, 32'd0);
    chk({tag, "_req_c2"}, {31'd0, bus_if.bus_req}, 32'd0);
    chk({tag, "_rdata"}, rdata, exp);
    cyc();
    req.ce = 1'b0;
    settle();
  endtask

  initial begin
    rst              = 1'b0;
    req              = '0;
    op               = OP_NOP;
    rt_old           = 32'h0;
    except_i         = 1'b0;
    flush            = 1'b0;
    stall_i          = 1'b0;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;

    // Reset state
    #3;
    chk("rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_if.bus_we}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_if.bus_err}, 32'd0);
    chk("rst_bus_addr", bus_if.bus_addr, 32'd0);
    chk("rst_bus_sel", {28'd0, bus_if.bus_sel}, 32'd0);
    chk("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    #9 rst = 1'b1;

    // LB, byte 3 of 0x80FF1234 = 0x80, sign-extended
    tx_base = tx_cnt;
    do_load("lb", OP_LB, 32'h8000_0003, 4'b0001, 32'h0, 32'h80FF_1234, 32'hFFFF_FF80);
    chk("lb_tx", tx_cnt, tx_base + 1);

    // SW with 3 wait states: bus stable cycles 1-4, stall cycles 0-4
    cyc();
    issue(1'b1, 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF, OP_SW, 32'h0);
    settle();
    chk("sw_stall_c0", {31'd0, stall_req}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("sw_req_c%0d", k), {31'd0, bus_if.bus_req}, 32'd1);
      chk($sformatf("sw_we_c%0d", k), {31'd0, bus_if.bus_we}, 32'd1);
      chk($sformatf("sw_addr_c%0d", k), bus_if.bus_addr, 32'h0000_1000);
      chk($sformatf("sw_wdata_c%0d", k), bus_if.bus_wdata, 32'hDEAD_BEEF);
      if (k == 4) bus_if.bus_ack = 1'b1;
      settle();
      chk($sformatf("sw_stall_c%0d", k), {31'd0, stall_req}, 32'd1);
    end
    cyc();
    bus_if.bus_ack = 1'b0;
    settle();
    chk("sw_stall_c5", {31'd0, stall_req}, 32'd0);
    chk("sw_req_c5", {31'd0, bus_if.bus_req}, 32'd0);
    chk("sw_rdata_kept", rdata, 32'hFFFF_FF80);
    cyc();
    req.ce = 1'b0;
    settle();

    // Alignment / extension / merge vectors
    do_load("lwl", OP_LWL, 32'h0000_2001, 4'b1111, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344);
    do_load("lbu", OP_LBU, 32'h0000_2002, 4'b0100, 32'h0, 32'h12AB_5678, 32'h0000_00AB);
    do_load("lb1", OP_LB, 32'h0000_2001, 4'b0010, 32'h0, 32'h0000_7F00, 32'h0000_007F);
    do_load("lh", OP_LH, 32'h0000_2002, 4'b1100, 32'h0, 32'h8001_7FFF, 32'hFFFF_8001);
    do_load("lhu", OP_LHU, 32'h0000_2000, 4'b0011, 32'h0, 32'h1234_F00D, 32'h0000_F00D);
    do_load("lwr", OP_LWR, 32'h0000_2002, 4'b1111, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_AABB);
    do_load("lw", OP_LW, 32'h0000_2000, 4'b1111, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Flush in BUSY: flush in cycle 1, ack in cycle 3, data discarded
    tx_base = tx_cnt;
    cyc();
    issue(1'b0, 32'h0000_3000, 4'b1111, 32'h0, OP_LW, 32'h0);
    settle();
    cyc();
    flush = 1'b1;
    settle();
    chk("fl_req_c1", {31'd0, bus_if.bus_req}, 32'd1);
    cyc();
    flush  = 1'b0;
    req.ce = 1'b0;
    settle();
    chk("fl_req_c2", {31'd0, bus_if.bus_req}, 32'd1);
    chk("fl_addr_c2", bus_if.bus_addr, 32'h0000_3000);
    cyc();
    chk("fl_req_c3", {31'd0, bus_if.bus_req}, 32'd1);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h5555_5555;
    settle();
    cyc();
    bus_if.bus_ack = 1'b0;
    settle();
    chk("fl_req_c4", {31'd0, bus_if.bus_req}, 32'd0);
    chk("fl_rdata_kept", rdata, 32'hCAFE_F00D);
    cyc();
    cyc();
    chk("fl_no_reissue", {31'd0, bus_if.bus_req}, 32'd0);
    chk("fl_tx", tx_cnt, tx_base + 1);

    // Held in DONE for 4 cycles with the request still presented
    tx_base = tx_cnt;
    cyc();
    issue(1'b0, 32'h0000_4000, 4'b1111, 32'h0, OP_LW, 32'h0);
    settle();
    cyc();
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h0BAD_F00D;
    settle();
    for (int k = 2; k <= 5; k++) begin
      cyc();
      bus_if.bus_ack = 1'b0;
      stall_i        = 1'b1;
      settle();
      chk($sformatf("hold_req_c%0d", k), {31'd0, bus_if.bus_req}, 32'd0);
      chk($sformatf("hold_stall_c%0d", k), {31'd0, stall_req}, 32'd0);
    end
    cyc();
    stall_i = 1'b0;
    settle();
    chk("hold_stall_c6", {31'd0, stall_req}, 32'd0);
    cyc();
    req.ce = 1'b0;
    settle();
    cyc();
    chk("hold_rdata", rdata, 32'h0BAD_F00D);
    chk("hold_tx", tx_cnt, tx_base + 1);

    // Faulted instruction: no access; stray ack in IDLE is ignored
    cyc();
    issue(1'b0, 32'h0000_4800, 4'b1111, 32'h0, OP_LW, 32'h0);
    except_i         = 1'b1;
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h7777_7777;
    settle();
    chk("exc_stall", {31'd0, stall_req}, 32'd0);
    cyc();
    chk("exc_req", {31'd0, bus_if.bus_req}, 32'd0);
    chk("exc_rdata", rdata, 32'h0BAD_F00D);
    req.ce         = 1'b0;
    except_i       = 1'b0;
    bus_if.bus_ack = 1'b0;
    settle();

    // Watchdog: silent slave, error pulse in cycle 9
    cyc();
    issue(1'b0, 32'h0000_5000, 4'b1111, 32'h0, OP_LW, 32'h0);
    settle();
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk($sformatf("wd_req_c%0d", k), {31'd0, bus_if.bus_req}, 32'd1);
      chk($sformatf("wd_err_c%0d", k), {31'd0, bus_if.bus_err}, 32'd0);
      chk($sformatf("wd_stall_c%0d", k), {31'd0, stall_req}, 32'd1);
    end
    cyc();
    chk("wd_err_c9", {31'd0, bus_if.bus_err}, 32'd1);
    chk("wd_req_c9", {31'd0, bus_if.bus_req}, 32'd0);
    chk("wd_rdata_c9", rdata, 32'd0);
    chk("wd_stall_c9", {31'd0, stall_req}, 32'd0);
    cyc();
    req.ce = 1'b0;
    settle();
    chk("wd_err_c10", {31'd0, bus_if.bus_err}, 32'd0);

    // Ack in the same cycle as the limit wins over the watchdog
    cyc();
    issue(1'b0, 32'h0000_6000, 4'b1111, 32'h0, OP_LW, 32'h0);
    settle();
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 8) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h600D_600D;
      end
      settle();
    end
    cyc();
    bus_if.bus_ack = 1'b0;
    settle();
    chk("lim_err_c9", {31'd0, bus_if.bus_err}, 32'd0);
    chk("lim_req_c9", {31'd0, bus_if.bus_req}, 32'd0);
    chk("lim_rdata_c9", rdata, 32'h600D_600D);
    cyc();
    req.ce = 1'b0;
    settle();
    cyc();
    chk("lim_err_c10", {31'd0, bus_if.bus_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_data_access.md
# mem_data_access

Memory-stage responder for the execute stage's `memControl_t` request. It turns each load or store into one transaction on the data bus and holds the pipeline with `stall_req` until the slave acknowledges. Load data is byte-lane aligned, sign- or zero-extended, or merged for LWL/LWR, then returned on `rdata` for write-back. It sits between the EX/MEM pipeline register and the data-bus arbiter.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 0: bus watchdog limit in cycles; 0 disables the watchdog.

Ports (`name direction width meaning`):
- `clk  in  1` — the only clock.
- `rst  in  1` — reset, asynchronous, active-low.
- `req  in  memControl_t` — request from EX/MEM: ce, we, addr (physical), sel, wdata. The invalidate_* fields are ignored.
- `op  in  exOperation_t` — load kind: OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL, OP_LWL, OP_LWR, OP_LWC1.
- `rt_old  in  32` — old rt value, used for LWL/LWR merge.
- `except_i  in  1` — an exception is already flagged on this instruction; suppresses the access.
- `flush  in  1` — pipeline flush.
- `stall_i  in  1` — a later stage is holding the pipeline.
- `stall_req  out  1` — hold request to the hazard unit.
- `rdata  out  32` — final load result.
- `bus_req  out  1`, `bus_we  out  1`, `bus_addr  out  32`, `bus_sel  out  4`, `bus_wdata  out  32` — bus request outputs, all registered.
- `bus_ack  in  1` — single-cycle acknowledge from the slave.
- `bus_rdata  in  32` — slave read data, valid while `bus_ack` is high.
- `bus_err  out  1` — one-cycle pulse when the watchdog expires.

## Operation
- The FSM state is `memState_t`: IDLE, BUSY, DONE, ABORT.
- **IDLE**: if `req.ce & ~except_i & ~flush`, latch `req` into the bus registers, set `bus_req`, go to BUSY.
- **BUSY**: hold every bus output stable until `bus_ack`. On ack: drop `bus_req`, register the aligned result into `rdata` (loads only; stores leave `rdata` unchanged), go to DONE.
- **DONE**: go to IDLE when `stall_i == 0`. This stops a held instruction from issuing twice.
- **Flush in BUSY**: go to ABORT. `bus_req` stays high until `bus_ack` (bus transactions are never cancelled), the data is discarded, then the FSM goes to IDLE.
- **Flush in DONE**: go to IDLE.
- `stall_req = req.ce & ~except_i & (state != DONE)`. It is combinational and includes the request cycle in IDLE and all of ABORT.
- **Watchdog** (`TIMEOUT_CYCLES > 0`):
  - A counter clears on entry to BUSY and counts each cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`, drop `bus_req`, pulse `bus_err`, set `rdata = 0`, go to DONE.
  - An ack that arrives in the same cycle as the limit wins.
- **Byte lanes**: little-endian; `sel[i]` enables bits `8i+7:8i`.
- **Load alignment**, by `addr[1:0]`:
  - LB/LBU: extract the addressed byte.
  - LH/LHU: use `addr[1]` to pick the half-word.
  - LWL: byte offset 0/1/2/3 gives {m[7:0],rt[23:0]}, {m[15:0],rt[15:0]}, {m[23:0],rt[7:0]}, m.
  - LWR: byte offset 0/1/2/3 gives m, {rt[31:24],m[31:8]}, {rt[31:16],m[31:16]}, {rt[31:8],m[31:24]}.

## Timing
- Reset values: `bus_req`, `bus_we`, `bus_err` = 0; `bus_addr`, `bus_sel`, `bus_wdata`, `rdata` = 0; state = IDLE.
- Request seen in cycle 0, `bus_req` high from cycle 1. With a zero-wait slave (ack in cycle 1), the FSM is in DONE with `rdata` valid in cycle 2, and `stall_req` falls in cycle 2. Minimum stall is 2 cycles; each slave wait state adds 1.
- `bus_ack` is ignored outside BUSY and ABORT.
- A new request arriving in the cycle the FSM returns to IDLE is accepted in that same cycle.

## Structure
- Add to `defines.svh`: the `memState_t` enum and the `dbusReq_t` struct (req, we, addr, sel, wdata).
- Sub-module `mem_load_align`: combinational alignment, extension and LWL/LWR merge, with inputs op, addr[1:0], bus_rdata, rt_old.
- Top level holds the FSM, the bus registers and the watchdog counter.

## Test plan
- **LB**: LB at 0x8000_0003, slave returns 0x80FF_1234 with 0 waits → `bus_sel=0001` is passed through; `rdata=0xFFFF_FF80`; `stall_req` high for exactly cycles 0–1.
- **SW with waits**: SW 0xDEAD_BEEF, ack after 3 wait states → `bus_*` stable for 4 cycles, 5-cycle stall, `rdata` unchanged.
- **LWL**: addr[1:0]=01, rt_old=0x1122_3344, mem=0xAABB_CCDD → `rdata=0xCCDD_3344`.
- **Flush in BUSY**: flush one cycle after issue, ack 2 cycles later → `bus_req` held until ack, `rdata` unchanged, no second issue.
- **Held in DONE**: `stall_i` high for 4 cycles after completion → exactly one `bus_req` transaction.
- **Watchdog**: `TIMEOUT_CYCLES=8`, slave never acks → `bus_err` pulses in cycle 9, `rdata=0`, stall released.
